// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 widths and program-loader FSM state encodings
package sap1_pkg;
  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/ram_loader.sv
// ram_loader: streams bytes into the SAP-1 program RAM from address 0, then optionally re-reads and checksums the image
module ram_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W = SAP1_ADDR_W,
  parameter int DATA_W = SAP1_DATA_W,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] csum_o
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  logic [2:0]        r_state;
  logic [2:0]        w_nx;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_rsum;
  logic [DATA_W-1:0] r_csum;
  logic              r_err;
  logic [ADDR_W:0]   w_len;
  logic [ADDR_W:0]   w_cnt_nx;
  logic [DATA_W-1:0] w_rsum_nx;
  logic              w_hs;
  logic              w_last_hs;
  logic              w_last_chk;
  assign w_len      = (len_i > DEPTH) ? DEPTH : len_i;
  assign w_hs       = s_valid_i & (r_state == ST_LOAD);
  assign w_cnt_nx   = r_cnt + (ADDR_W+1)'(1);
  assign w_last_hs  = w_hs & (w_cnt_nx == r_len);
  assign w_rsum_nx  = r_rsum + mem_rdata_i;
  assign w_last_chk = {1'b0, r_addr} == r_len - (ADDR_W+1)'(1);
  assign s_ready_o   = r_state == ST_LOAD;
  assign busy_o      = (r_state == ST_LOAD) | (r_state == ST_FLUSH) | (r_state == ST_CHECK);
  assign done_o      = r_state == ST_DONE;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign err_o       = r_err;
  assign csum_o      = r_csum;
  // next-state selection; a zero-length load skips straight to DONE
  always_comb
    w_nx = (r_state == ST_IDLE)  ? (start_i ? ((w_len == '0) ? ST_DONE : ST_LOAD) : ST_IDLE) :
           (r_state == ST_LOAD)  ? (w_last_hs ? ST_FLUSH : ST_LOAD) :
           (r_state == ST_FLUSH) ? (VERIFY ? ST_CHECK : ST_DONE) :
           (r_state == ST_CHECK) ? (w_last_chk ? ST_DONE : ST_CHECK) : ST_IDLE;
  // state, write pipeline register, address counter and the two running sums
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_sum   <= '0;
      r_rsum  <= '0;
      r_csum  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nx;
      r_we    <= w_hs;
      if (r_state == ST_IDLE && start_i) begin
        r_len  <= w_len;
        r_cnt  <= '0;
        r_addr <= '0;
        r_sum  <= '0;
        r_err  <= 1'b0;
      end
      if (w_hs) begin
        r_wdata <= s_data_i;
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_cnt   <= w_cnt_nx;
        r_sum   <= r_sum + s_data_i;
      end
      if (r_state == ST_FLUSH && VERIFY) begin
        r_addr <= '0;
        r_rsum <= '0;
      end
      if (r_state == ST_CHECK) begin
        r_rsum <= w_rsum_nx;
        if (w_last_chk) r_err <= w_rsum_nx != r_sum;
        else r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_nx == ST_DONE) r_csum <= (r_state == ST_IDLE) ? '0 : r_sum;
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized and directed loads against a queue/array reference of the program image
module tb_ram_loader;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] len_i = '0;
  logic       s_valid_i = 1'b0;
  logic [7:0] s_data_i = '0;
  logic       s_ready_o;
  logic       mem_we_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [7:0] csum_o;
  logic [7:0] ram [0:15];
  logic [7:0] src [0:31];
  bit         corrupt_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  ram_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .csum_o(csum_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;

  assign mem_rdata_i = (corrupt_en && busy_o && !mem_we_o && mem_addr_o == 4'd2) ? 8'hFF : ram[mem_addr_o];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_load(input int len, input int n_avail, input int gap_pct, input int gap_at,
                          input bit corrupt, input bit poke);
    int exp_n, idx, wr, lat, gcnt;
    logic [7:0] exp_sum;
    bit hs, prev_hs, img_ok;
    exp_n = len > 16 ? 16 : len;
    exp_sum = '0;
    for (int k = 0; k < exp_n; k++) exp_sum += src[k];
    corrupt_en = corrupt;
    idx = 0; wr = 0; lat = 0; gcnt = 0; hs = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    len_i = len[4:0];
    s_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 100 && lat == 0; cyc++) begin
      @(negedge clk_i);
      start_i = poke && cyc == 3;
      if (poke) len_i = 5'd2;
      prev_hs = hs;
      if (prev_hs) idx++;
      if (cyc == 1) chk("err_clr", 32'(err_o), 0);
      chk("we_lat", 32'(mem_we_o), 32'(prev_hs));
      if (mem_we_o) begin
        chk("waddr", 32'(mem_addr_o), wr);
        chk("wdata", 32'(mem_wdata_o), 32'(src[wr]));
        wr++;
      end
      if (idx >= exp_n) chk("rdy_off", 32'(s_ready_o), 0);
      if (done_o) begin
        lat = cyc;
        chk("busy_done", 32'(busy_o), 0);
      end else chk("busy", 32'(busy_o), 32'(exp_n != 0));
      s_valid_i = idx < n_avail && !(idx == gap_at && gcnt < 3) && ($urandom_range(99) >= gap_pct);
      if (idx == gap_at && gcnt < 3) gcnt++;
      s_data_i = src[idx];
      hs = s_valid_i && s_ready_o;
    end
    s_valid_i = 1'b0;
    chk("done_seen", 32'(lat != 0), 1);
    if (exp_n == 0) chk("lat_len0", 32'(lat <= 2), 1);
    else if (gap_pct == 0 && gap_at < 0) chk("lat", lat, 2 * exp_n + 2);
    chk("accepted", idx, exp_n);
    chk("writes", wr, exp_n);
    chk("csum", 32'(csum_o), 32'(exp_sum));
    chk("err", 32'(err_o), 32'(corrupt));
    img_ok = 1'b1;
    for (int k = 0; k < exp_n; k++) if (ram[k] !== src[k]) img_ok = 1'b0;
    chk("image", 32'(img_ok), 1);
    corrupt_en = 1'b0;
    @(negedge clk_i);
    chk("done_pulse", 32'(done_o), 0);
    chk("we_idle", 32'(mem_we_o), 0);
    chk("rdy_idle", 32'(s_ready_o), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(mem_we_o), 0);
    chk({tag, "_rdy"}, 32'(s_ready_o), 0);
    chk({tag, "_addr"}, 32'(mem_addr_o), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_csum"}, 32'(csum_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit cor;
    for (int k = 0; k < 16; k++) ram[k] = 8'h00;
    repeat (2) @(negedge clk_i);
    chk_zero("rst");
    rst_ni = 1'b1;
    @(negedge clk_i);
    src[0] = 8'h09; src[1] = 8'h1A; src[2] = 8'h1B; src[3] = 8'h2C;
    run_load(4, 4, 0, -1, 1'b0, 1'b0);
    run_load(4, 4, 0, 2, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) src[k] = 8'(k);
    run_load(16, 16, 0, -1, 1'b0, 1'b0);
    src[0] = 8'h09; src[1] = 8'h1A; src[2] = 8'h1B; src[3] = 8'h2C;
    run_load(4, 4, 0, -1, 1'b1, 1'b0);
    run_load(0, 0, 0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) src[k] = 8'($urandom_range(255));
    run_load(20, 20, 0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) src[k] = 8'($urandom_range(255));
    run_load(6, 6, 0, -1, 1'b0, 1'b1);
    @(negedge clk_i);
    start_i = 1'b1;
    len_i = 5'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = src[0];
    @(negedge clk_i);
    s_data_i = src[1];
    @(negedge clk_i);
    s_data_i = src[2];
    #2 rst_ni = 1'b0;
    #1 chk_zero("abort");
    repeat (3) begin
      @(negedge clk_i);
      chk("abort_hold_we", 32'(mem_we_o), 0);
    end
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("post_abort_we", 32'(mem_we_o), 0);
      chk("post_abort_busy", 32'(busy_o), 0);
    end
    s_valid_i = 1'b0;
    repeat (12) begin
      for (int k = 0; k < 32; k++) src[k] = 8'($urandom_range(255));
      len = $urandom_range(20);
      cor = len > 2 && src[2] != 8'hFF && $urandom_range(1) == 1;
      run_load(len, len, $urandom_range(50), -1, cor, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
